// File: rtl/acl_stream_pkg.sv
// Shared types and constants for the ACL ingress stream path.
package acl_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int ETH_MAX_FRAME_BYTES = 1518;
    localparam int BYTES_PER_BEAT      = 4;

    // Number of stream beats needed to carry n bytes (rounded up).
    function automatic int beats_for_bytes(input int n);
        return (n + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
    endfunction

endpackage

// File: rtl/acl_rr_pick.sv
// Two-requester round-robin picker. Remembers the last port that finished
// a frame and, on a tie, favours the other one.
module acl_rr_pick
    import acl_stream_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic upd_grant,
    output logic pick_valid,
    output logic pick
);

    logic last_grant;

    // Last-served port; resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= upd_grant;
        end
    end

    // Single requester wins outright; a tie goes to the port not served last.
    always_comb begin
        pick_valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
    end

endmodule

// File: rtl/acl_ingress_arbiter.sv
// Frame-granular arbiter merging two receive streams onto the single
// ACL/FIFO ingress port. A grant is held from first beat to tlast; oversize
// frames are cut at MAX_BEATS and stalled frames are aborted, after which the
// rest of the offending frame is drained from its source.
module acl_ingress_arbiter
    import acl_stream_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int MAX_BEATS      = beats_for_bytes(ETH_MAX_FRAME_BYTES),
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rxd0_tvalid,
    input  logic              i_rxd0_tlast,
    input  logic [DATA_W-1:0] i_rxd0_tdata,
    output logic              o_rxd0_tready,
    input  logic              i_rxd1_tvalid,
    input  logic              i_rxd1_tlast,
    input  logic [DATA_W-1:0] i_rxd1_tdata,
    output logic              o_rxd1_tready,
    output logic              o_txd_tvalid,
    output logic              o_txd_tlast,
    output logic [DATA_W-1:0] o_txd_tdata,
    output logic              o_txd_tuser,
    input  logic              i_txd_tready,
    output logic              o_grant,
    output logic              o_frame_done,
    output logic [CNT_W-1:0]  o_frame_beats,
    output logic              o_abort
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              upd_last;
    logic              pick_valid, pick;
    logic              sel_tvalid, sel_tlast, sel_tready;
    logic [DATA_W-1:0] sel_tdata;

    acl_rr_pick u_pick (
        .clk        (clk),
        .rst        (rst),
        .req0       (i_rxd0_tvalid),
        .req1       (i_rxd1_tvalid),
        .update     (upd_last),
        .upd_grant  (grant_q),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // Source mux driven by the registered grant.
    always_comb begin
        sel_tvalid = grant_q ? i_rxd1_tvalid : i_rxd0_tvalid;
        sel_tlast  = grant_q ? i_rxd1_tlast  : i_rxd0_tlast;
        sel_tdata  = grant_q ? i_rxd1_tdata  : i_rxd0_tdata;
    end

    assign o_rxd0_tready = sel_tready & ~grant_q;
    assign o_rxd1_tready = sel_tready &  grant_q;
    assign o_grant       = grant_q;

    // Arbitration state, grant and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Next-state and output decode; XFER is a zero-latency pass-through.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        upd_last      = 1'b0;
        sel_tready    = 1'b0;
        o_txd_tvalid  = 1'b0;
        o_txd_tlast   = 1'b0;
        o_txd_tdata   = '0;
        o_txd_tuser   = 1'b0;
        o_frame_done  = 1'b0;
        o_frame_beats = '0;
        o_abort       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick;
                    state_d    = XFER;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end

            XFER: begin
                sel_tready   = i_txd_tready;
                o_txd_tvalid = sel_tvalid;
                o_txd_tdata  = sel_tdata;
                o_txd_tlast  = sel_tlast;
                if (sel_tvalid && i_txd_tready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    idle_cnt_d = '0;
                    if (sel_tlast) begin
                        o_frame_done  = 1'b1;
                        o_frame_beats = beat_cnt_q + CNT_W'(1);
                        upd_last      = 1'b1;
                        state_d       = IDLE;
                    end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                        // Oversize: close the frame here and flag it as truncated.
                        o_txd_tlast   = 1'b1;
                        o_txd_tuser   = 1'b1;
                        o_frame_done  = 1'b1;
                        o_frame_beats = CNT_W'(MAX_BEATS);
                        state_d       = DRAIN;
                    end
                end else if (!sel_tvalid) begin
                    if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        o_abort    = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else begin
                    // Downstream back-pressure with data pending is not idleness.
                    idle_cnt_d = '0;
                end
            end

            DRAIN: begin
                sel_tready = 1'b1;
                if (sel_tvalid) begin
                    idle_cnt_d = '0;
                    if (sel_tlast) begin
                        upd_last = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_d = '0;
                    upd_last   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_acl_ingress_arbiter.sv
// Bench for acl_ingress_arbiter: per-source frame queues drive the DUT and a
// frame-level model predicts forwarded beats, frame outcomes and grant order.
`timescale 1ns/1ps
module tb_acl_ingress_arbiter;

    localparam int MAXB = 380;   // ceil(1518 / 4)
    localparam int TMO  = 64;

    typedef struct { logic [31:0] data; logic last; int gap; } sbeat_t;
    typedef struct { logic [31:0] data; logic last; logic user; } xbeat_t;
    typedef struct { bit is_abort; int beats; } outc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx_valid;
    logic [1:0]  rx_last;
    logic [31:0] rx_data [2];
    logic        txd_ready;
    logic        o_rxd0_tready, o_rxd1_tready;
    logic        o_txd_tvalid, o_txd_tlast, o_txd_tuser;
    logic [31:0] o_txd_tdata;
    logic        o_grant, o_frame_done, o_abort;
    logic [8:0]  o_frame_beats;

    acl_ingress_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_rxd0_tvalid (rx_valid[0]),
        .i_rxd0_tlast  (rx_last[0]),
        .i_rxd0_tdata  (rx_data[0]),
        .o_rxd0_tready (o_rxd0_tready),
        .i_rxd1_tvalid (rx_valid[1]),
        .i_rxd1_tlast  (rx_last[1]),
        .i_rxd1_tdata  (rx_data[1]),
        .o_rxd1_tready (o_rxd1_tready),
        .o_txd_tvalid  (o_txd_tvalid),
        .o_txd_tlast   (o_txd_tlast),
        .o_txd_tdata   (o_txd_tdata),
        .o_txd_tuser   (o_txd_tuser),
        .i_txd_tready  (txd_ready),
        .o_grant       (o_grant),
        .o_frame_done  (o_frame_done),
        .o_frame_beats (o_frame_beats),
        .o_abort       (o_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus queues, model expectations and observation records.
    sbeat_t src_q [2][$];
    xbeat_t exp_beats [2][$];
    outc_t  exp_out [2][$];
    int     exp_order[$];
    int     starts[$];
    sbeat_t pend [2];
    bit     loaded [2];
    bit     flush = 1'b0;
    int     txd_mode = 0;
    int     last_served = 1;
    int     fid = 0;
    int     checks = 0;
    int     errors = 0;
    bit     in_frame = 1'b0;
    int     fwd_count [2];
    int     drained [2];
    int     n_abort = 0;
    int     first_fwd_cyc, last_fwd_cyc, last_done_cyc, abort_delay;
    logic [31:0] last_fwd_data;
    logic [8:0]  last_done_beats;
    logic        last_done_user;
    logic [1:0]  drv_hs;
    logic [1:0]  cmp_rdy;
    int          cmp_g;
    xbeat_t      cmp_xb;
    outc_t       cmp_oc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none-expected (cycle %0d)", nm, act, cyc);
    endtask

    function automatic logic [31:0] pat(input int k);
        int b;
        b = 4 * k - 7;
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    // Frame model: a frame of L beats forwards beats until tlast, until beat
    // MAXB (forced tlast+tuser), or until a gap of TMO or more idle cycles
    // (abort); everything after that is swallowed by the arbiter.
    task automatic add_frame(input int s, input int len, input int ab_at, input int ab_gap,
                             input bit rgap, input bit patt);
        sbeat_t sb;
        xbeat_t xb;
        outc_t  oc;
        bit     fwd;
        fwd = 1'b1;
        fid++;
        for (int k = 1; k <= len; k++) begin
            if (k == 1) sb.gap = 0;
            else if (ab_at > 0 && k == ab_at + 1) sb.gap = ab_gap;
            else if (rgap && $urandom_range(0, 3) == 0) sb.gap = int'($urandom_range(1, 3));
            else sb.gap = 0;
            sb.data = patt ? pat(k) : {s[0], 7'(fid), 8'h00, 16'(k)};
            sb.last = (k == len);
            src_q[s].push_back(sb);
            if (fwd && sb.gap >= TMO) begin
                oc.is_abort = 1'b1; oc.beats = 0;
                exp_out[s].push_back(oc);
                fwd = 1'b0;
            end
            if (fwd) begin
                xb.data = sb.data;
                if (k == len) begin
                    xb.last = 1'b1; xb.user = 1'b0;
                    oc.is_abort = 1'b0; oc.beats = len;
                    exp_out[s].push_back(oc);
                end else if (k == MAXB) begin
                    xb.last = 1'b1; xb.user = 1'b1;
                    oc.is_abort = 1'b0; oc.beats = MAXB;
                    exp_out[s].push_back(oc);
                    fwd = 1'b0;
                end else begin
                    xb.last = 1'b0; xb.user = 1'b0;
                end
                exp_beats[s].push_back(xb);
            end
        end
    endtask

    // Both backlogged: alternate away from the last served port.
    task automatic push_order(input int n0, input int n1);
        int a, b, nxt;
        a = n0; b = n1;
        while (a > 0 || b > 0) begin
            if (a > 0 && b > 0) nxt = (last_served == 0) ? 1 : 0;
            else nxt = (a > 0) ? 0 : 1;
            exp_order.push_back(nxt);
            if (nxt == 0) a--; else b--;
            last_served = nxt;
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && !loaded[0] && !loaded[1] &&
                 rx_valid == 2'b00 && exp_beats[0].size() == 0 && exp_beats[1].size() == 0 &&
                 exp_out[0].size() == 0 && exp_out[1].size() == 0 && exp_order.size() == 0)) begin
            @(posedge clk);
            n++;
            if (n > 30000) begin
                note_fail({nm, "_timeout"}, 32'(exp_beats[0].size() + exp_beats[1].size()));
                finish_now();
            end
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_txd_tvalid"}, 32'(o_txd_tvalid), 0);
        chk({tag, "_txd_tlast"}, 32'(o_txd_tlast), 0);
        chk({tag, "_txd_tuser"}, 32'(o_txd_tuser), 0);
        chk({tag, "_rxd0_tready"}, 32'(o_rxd0_tready), 0);
        chk({tag, "_rxd1_tready"}, 32'(o_rxd1_tready), 0);
        chk({tag, "_frame_done"}, 32'(o_frame_done), 0);
        chk({tag, "_frame_beats"}, 32'(o_frame_beats), 0);
        chk({tag, "_abort"}, 32'(o_abort), 0);
        chk({tag, "_grant"}, 32'(o_grant), 0);
    endtask

    // Source drivers and downstream ready generator.
    initial begin
        rx_valid = 2'b00; rx_last = 2'b00; rx_data[0] = '0; rx_data[1] = '0;
        txd_ready = 1'b0; loaded[0] = 1'b0; loaded[1] = 1'b0;
        forever begin
            @(negedge clk);
            drv_hs = rx_valid & {o_rxd1_tready, o_rxd0_tready};
            @(posedge clk);
            #1;
            case (txd_mode)
                0: txd_ready = 1'b1;
                1: txd_ready = ~txd_ready;
                default: txd_ready = ($urandom_range(0, 3) != 0);
            endcase
            for (int s = 0; s < 2; s++) begin
                if (flush) begin
                    src_q[s].delete();
                    loaded[s] = 1'b0; rx_valid[s] = 1'b0; rx_last[s] = 1'b0;
                end else begin
                    if (drv_hs[s]) begin rx_valid[s] = 1'b0; rx_last[s] = 1'b0; end
                    if (!rx_valid[s]) begin
                        if (!loaded[s] && src_q[s].size() > 0) begin
                            pend[s] = src_q[s].pop_front();
                            loaded[s] = 1'b1;
                        end
                        if (loaded[s]) begin
                            if (pend[s].gap > 0) pend[s].gap--;
                            else begin
                                rx_valid[s] = 1'b1;
                                rx_last[s]  = pend[s].last;
                                rx_data[s]  = pend[s].data;
                                loaded[s]   = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                cmp_rdy = {o_rxd1_tready, o_rxd0_tready};
                chk("tready_exclusive", 32'(cmp_rdy == 2'b11), 0);
                for (int s = 0; s < 2; s++)
                    if (rx_valid[s] && cmp_rdy[s] && !(o_txd_tvalid && txd_ready)) drained[s]++;
                if (o_txd_tvalid && txd_ready) begin
                    cmp_g = int'(o_grant);
                    chk("fwd_tready_onehot", 32'(cmp_rdy), (cmp_g == 1) ? 32'd2 : 32'd1);
                    if (!in_frame) begin
                        starts.push_back(cmp_g);
                        if (first_fwd_cyc < 0) first_fwd_cyc = cyc;
                        if (exp_order.size() == 0) note_fail("grant_order", 32'(cmp_g));
                        else chk("grant_order", 32'(cmp_g), 32'(exp_order.pop_front()));
                        in_frame = 1'b1;
                    end
                    if (exp_beats[cmp_g].size() == 0) note_fail("unexpected_beat", o_txd_tdata);
                    else begin
                        cmp_xb = exp_beats[cmp_g].pop_front();
                        chk("beat_data", o_txd_tdata, cmp_xb.data);
                        chk("beat_tlast", 32'(o_txd_tlast), 32'(cmp_xb.last));
                        if (cmp_xb.last) chk("beat_tuser", 32'(o_txd_tuser), 32'(cmp_xb.user));
                    end
                    last_fwd_cyc = cyc; last_fwd_data = o_txd_tdata;
                    fwd_count[cmp_g]++;
                end
                if (o_frame_done) begin
                    cmp_g = int'(o_grant);
                    if (exp_out[cmp_g].size() == 0) note_fail("unexpected_done", 32'(o_frame_beats));
                    else begin
                        cmp_oc = exp_out[cmp_g].pop_front();
                        chk("done_not_abort", 0, 32'(cmp_oc.is_abort));
                        chk("frame_beats", 32'(o_frame_beats), 32'(cmp_oc.beats));
                    end
                    in_frame = 1'b0;
                    last_done_beats = o_frame_beats; last_done_user = o_txd_tuser; last_done_cyc = cyc;
                end
                if (o_abort) begin
                    cmp_g = int'(o_grant);
                    if (exp_out[cmp_g].size() == 0) note_fail("unexpected_abort", 1);
                    else begin
                        cmp_oc = exp_out[cmp_g].pop_front();
                        chk("abort_expected", 1, 32'(cmp_oc.is_abort));
                    end
                    in_frame = 1'b0;
                    abort_delay = cyc - last_fwd_cyc;
                    n_abort++;
                end
            end
        end
    end

    int base, na, n;

    initial begin
        fwd_count[0] = 0; fwd_count[1] = 0; drained[0] = 0; drained[1] = 0;
        first_fwd_cyc = -1; last_fwd_cyc = 0; last_done_cyc = 0; abort_delay = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // Both sources backlogged with three 16-beat frames each.
        first_fwd_cyc = -1;
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 16, 0, 0, 1'b0, 1'b0);
            add_frame(1, 16, 0, 0, 1'b0, 1'b0);
        end
        push_order(3, 3);
        wait_idle("alternate");
        chk("alternate_span_one_bubble", 32'(last_done_cyc - first_fwd_cyc), 100);

        // Single 1514-byte frame from source 0.
        add_frame(0, 379, 0, 0, 1'b0, 1'b1);
        chk("model_last_pattern", exp_beats[0][378].data, 32'hE5E6E7E8);
        push_order(1, 0);
        wait_idle("max_frame");
        chk("max_frame_beats", 32'(last_done_beats), 379);
        chk("max_frame_last_data", last_fwd_data, 32'hE5E6E7E8);
        chk("max_frame_tuser", 32'(last_done_user), 0);
        chk("max_frame_grant", 32'(o_grant), 0);

        // Oversize 400-beat frame from source 1.
        base = drained[1];
        add_frame(1, 400, 0, 0, 1'b0, 1'b0);
        push_order(0, 1);
        wait_idle("truncate");
        chk("trunc_beats", 32'(last_done_beats), 380);
        chk("trunc_tuser", 32'(last_done_user), 1);
        chk("trunc_drained", 32'(drained[1] - base), 20);

        // Source 0 stalls 64 cycles after beat 10; source 1 waits.
        na = n_abort;
        base = drained[0];
        add_frame(0, 30, 10, 64, 1'b0, 1'b0);
        add_frame(1, 12, 0, 0, 1'b0, 1'b0);
        push_order(1, 1);
        wait_idle("abort");
        chk("abort_count", 32'(n_abort - na), 1);
        chk("abort_delay", 32'(abort_delay), 64);
        chk("abort_drained", 32'(drained[0] - base), 20);

        // 100-beat frame under alternating back-pressure.
        txd_mode = 1;
        na = n_abort;
        add_frame(0, 100, 0, 0, 1'b0, 1'b0);
        push_order(1, 0);
        wait_idle("toggle");
        chk("toggle_beats", 32'(last_done_beats), 100);
        chk("toggle_no_abort", 32'(n_abort - na), 0);
        txd_mode = 0;

        // Reset in the middle of a source 1 frame.
        base = fwd_count[1];
        add_frame(1, 100, 0, 0, 1'b0, 1'b0);
        push_order(0, 1);
        n = 0;
        while (fwd_count[1] - base < 50) begin
            @(posedge clk);
            n++;
            if (n > 2000) begin
                note_fail("reset_phase_timeout", 32'(fwd_count[1] - base));
                finish_now();
            end
        end
        #2;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; flush = 1'b0;
        for (int s = 0; s < 2; s++) begin
            exp_beats[s].delete(); exp_out[s].delete();
        end
        exp_order.delete();
        in_frame = 1'b0;
        last_served = 1;
        @(negedge clk);
        check_reset("midframe_reset");
        @(posedge clk); #2;
        starts.delete();
        add_frame(0, 8, 0, 0, 1'b0, 1'b0);
        add_frame(1, 8, 0, 0, 1'b0, 1'b0);
        push_order(1, 1);
        wait_idle("after_reset");
        chk("after_reset_first_grant", (starts.size() > 0) ? 32'(starts[0]) : 32'hFFFF_FFFF, 0);

        // Randomized traffic with back-pressure, gaps, truncations and aborts.
        txd_mode = 2;
        for (int f = 0; f < 10; f++) begin
            for (int s = 0; s < 2; s++) begin
                int len, at, gp, lim;
                if ($urandom_range(0, 9) == 0) len = int'($urandom_range(378, 382));
                else len = int'($urandom_range(1, 40));
                at = 0; gp = 0;
                lim = (len < MAXB) ? len : MAXB;
                if (lim >= 2 && $urandom_range(0, 5) == 0) begin
                    at = int'($urandom_range(1, lim - 1));
                    gp = int'($urandom_range(TMO, TMO + 6));
                end
                add_frame(s, len, at, gp, 1'b1, 1'b0);
            end
        end
        push_order(10, 10);
        wait_idle("random");

        finish_now();
    end

endmodule
